uart_program_loader: RTL and testbench

Boot-time loader between the board `io_rx` pin and the CPU's instruction memory write port. It receives a length-prefixed program image over 8N1 UART and writes it word-by-word into program memory. It holds the CPU core in reset until the image is fully written, then releases the core and stays idle until the next system reset.

---
 rtl/uart_program_loader.sv | 181 ++++++++++++++++++
 tb/tb_uart_program_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART boot loader: receives a length-prefixed image over 8N1 and writes program memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data words.
module uart_program_loader #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_rx,
    output logic        prog_write_enable,
    output logic [31:0] prog_address,
    output logic [31:0] prog_write_data,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_error
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {L_LEN, L_DATA, L_CSUM, L_DONE} ld_state_t;
    logic [7:0] csum;
`else
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;
`endif

    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;

    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          byte_valid, frame_err;
    logic          tick_half, tick_full;

    logic [1:0]    lane;
    logic [23:0]   word_buf;
    logic [31:0]   word_next;
    logic [31:0]   word_count, word_idx;
    logic          last_word;

    assign tick_half = (cnt == HALF);
    assign tick_full = (cnt == FULL);
    assign word_next = {rx_shift, word_buf};
    assign load_done = (ld_state == L_DONE);
    assign cpu_reset_n = (ld_state == L_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            ld_state <= L_LEN;
        end else begin
            rx_state <= rx_next;
            ld_state <= ld_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (tick_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick_full) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        ld_next = ld_state;
        unique case (ld_state)
            L_LEN: if (byte_valid && lane == 2'd3)
                ld_next = (word_next == '0) ? L_DONE : L_DATA;
`ifdef LOADER_CHECKSUM_EN
            L_DATA: if (last_word) ld_next = L_CSUM;
            L_CSUM: if (byte_valid) ld_next = (rx_shift == csum) ? L_DONE : L_LEN;
`else
            L_DATA: if (last_word) ld_next = L_DONE;
`endif
            default: ld_next = ld_state;
        endcase
        if (frame_err && ld_state != L_DONE) ld_next = L_LEN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= io_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt <= (rx_state == RX_IDLE || rx_next != rx_state || tick_full)
                   ? '0 : cnt + CW'(1);
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && tick_full) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
            // Flagged one cycle after the stop sample, as RX re-enters idle
            if (rx_state == RX_STOP && tick_full) begin
                byte_valid <= rx_sync;
                frame_err  <= ~rx_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane              <= '0;
            word_buf          <= '0;
            word_count        <= '0;
            word_idx          <= '0;
            last_word         <= 1'b0;
            prog_write_enable <= 1'b0;
            prog_address      <= '0;
            prog_write_data   <= '0;
            load_error        <= 1'b0;
        end else begin
            prog_write_enable <= 1'b0;
            last_word         <= 1'b0;
            if (frame_err && ld_state != L_DONE) begin
                load_error <= 1'b1;
                lane       <= '0;
                word_idx   <= '0;
                word_count <= '0;
            end else if (byte_valid && (ld_state == L_LEN || ld_state == L_DATA)) begin
                lane     <= lane + 2'd1;
                word_buf <= word_next[31:8];
                if (lane == 2'd3) begin
                    if (ld_state == L_LEN) begin
                        word_count <= word_next;
                        word_idx   <= '0;
                    end else begin
                        // Words beyond memory capacity are drained silently
                        if (word_idx < 32'(MEM_WORDS)) begin
                            prog_write_enable <= 1'b1;
                            prog_address      <= {word_idx[29:0], 2'b00};
                            prog_write_data   <= word_next;
                        end
                        word_idx  <= word_idx + 32'd1;
                        last_word <= (word_idx + 32'd1 == word_count);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            else if (byte_valid && ld_state == L_CSUM && rx_shift != csum) begin
                load_error <= 1'b1;
                word_idx   <= '0;
                word_count <= '0;
            end
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (ld_state == L_LEN) begin
            csum <= '0;
        end else if (byte_valid && ld_state == L_DATA) begin
            csum <= csum ^ rx_shift;
        end
    end
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: table vectors, random images
// against a byte-stream model, and hand-written framing/glitch/reset sequences.
module tb_uart_program_loader;
    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int MEM_WORDS   = 4;
    localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_rx = 1'b1;
    logic        prog_write_enable;
    logic [31:0] prog_address;
    logic [31:0] prog_write_data;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD_RATE(BAUD_RATE),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_rx(io_rx),
        .prog_write_enable(prog_write_enable),
        .prog_address(prog_address),
        .prog_write_data(prog_write_data),
        .cpu_reset_n(cpu_reset_n),
        .load_done(load_done),
        .load_error(load_error)
    );

    int n_checks = 0;
    int n_fail = 0;
    longint cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        longint      at;
    } wr_t;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string            name;
        logic [31:0]      count;
        logic [7:0][31:0] w;
        int               exp_writes;
    } vec_t;

    wr_t    wr_q[$];
    logic   prev_we = 1'b0;
    bit     double_strobe = 0;
    longint done_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prog_write_enable) wr_q.push_back('{prog_address, prog_write_data, cyc});
        if (prog_write_enable && prev_we) double_strobe = 1;
        prev_we = prog_write_enable;
        if (load_done && done_at < 0) done_at = cyc;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        io_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wr_q.delete();
        double_strobe = 0;
        done_at = -1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        io_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        io_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Model: the byte stream an image is made of (length then words, LE)
    function automatic byte_q_t image_bytes(input logic [31:0] count,
                                            input logic [7:0][31:0] w);
        byte_q_t q;
        for (int i = 0; i < 4; i++) q.push_back(count[8*i +: 8]);
        for (int k = 0; k < int'(count); k++)
            for (int i = 0; i < 4; i++) q.push_back(w[k][8*i +: 8]);
        return q;
    endfunction

    function automatic logic [7:0] data_xor(input byte_q_t q);
        logic [7:0] x = 8'h00;
        for (int i = 4; i < q.size(); i++) x ^= q[i];
        return x;
    endfunction

    task automatic send_stream(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(data_xor(q), 0);
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !load_done; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_load(input string tag, input logic [31:0] count,
                              input logic [7:0][31:0] w, input int exp_writes,
                              input logic exp_error);
        check({tag, ".write_count"}, wr_q.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < wr_q.size(); i++) begin
            check({tag, ".addr"}, wr_q[i].addr, i * 4);
            check({tag, ".data"}, wr_q[i].data, w[i]);
        end
        check({tag, ".load_done"}, load_done, 1'b1);
        check({tag, ".cpu_reset_n"}, cpu_reset_n, 1'b1);
        check({tag, ".load_error"}, load_error, exp_error);
        check({tag, ".strobe_width"}, double_strobe, 0);
        if (exp_writes > 0) check({tag, ".addr_held"}, prog_address, (exp_writes - 1) * 4);
`ifndef LOADER_CHECKSUM_EN
        if (exp_writes > 0 && count <= MEM_WORDS && wr_q.size() > 0)
            check({tag, ".done_latency"}, 32'(done_at - wr_q[wr_q.size()-1].at), 1);
`endif
    endtask

    vec_t vecs[5];
    logic [7:0][31:0] spec_w;
    byte_q_t spec_q;

    initial begin
        vecs[0] = '{"one",      32'd1, '0, 1};
        vecs[1] = '{"zero",     32'd0, '0, 0};
        vecs[2] = '{"full",     32'd4, '0, 4};
        vecs[3] = '{"overflow", 32'd5, '0, 4};
        vecs[4] = '{"six",      32'd6, '0, 4};
        foreach (vecs[i])
            for (int k = 0; k < 8; k++) vecs[i].w[k] = $urandom();

        spec_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};
        spec_w = '0;
        spec_w[0] = 32'h0010_0513;
        spec_w[1] = 32'h0020_0593;

        // Reset state, held and after release with idle line
        #1;
        check("rst.we", prog_write_enable, 1'b0);
        check("rst.addr", prog_address, 32'h0);
        check("rst.data", prog_write_data, 32'h0);
        check("rst.cpu_reset_n", cpu_reset_n, 1'b0);
        check("rst.load_done", load_done, 1'b0);
        check("rst.load_error", load_error, 1'b0);
        apply_reset();
        repeat (300) @(negedge clk);
        check("idle.cpu_reset_n", cpu_reset_n, 1'b0);
        check("idle.load_done", load_done, 1'b0);
        check("idle.writes", wr_q.size(), 0);

        // Byte order taken directly from the literal byte stream
        apply_reset();
        send_stream(spec_q);
        wait_done();
        check_load("normal", 32'd2, spec_w, 2, 1'b0);

        foreach (vecs[i]) begin
            apply_reset();
            send_stream(image_bytes(vecs[i].count, vecs[i].w));
            wait_done();
            check_load(vecs[i].name, vecs[i].count, vecs[i].w, vecs[i].exp_writes, 1'b0);
        end

        for (int r = 0; r < 6; r++) begin
            logic [31:0] cnt;
            logic [7:0][31:0] w;
            cnt = $urandom_range(0, 6);
            for (int k = 0; k < 8; k++) w[k] = $urandom();
            apply_reset();
            send_stream(image_bytes(cnt, w));
            wait_done();
            check_load("random", cnt, w, (cnt < MEM_WORDS) ? int'(cnt) : MEM_WORDS, 1'b0);
        end

        // Framing error on the 2nd length byte, then a clean image
        apply_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 1);
        repeat (20) @(negedge clk);
        check("frame.load_error", load_error, 1'b1);
        check("frame.load_done", load_done, 1'b0);
        check("frame.cpu_reset_n", cpu_reset_n, 1'b0);
        send_stream(spec_q);
        wait_done();
        check_load("frame_reload", 32'd2, spec_w, 2, 1'b1);

        // 3-cycle glitch must not produce a byte
        apply_reset();
        io_rx = 1'b0;
        repeat (3) @(negedge clk);
        io_rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch.load_error", load_error, 1'b0);
        send_stream(image_bytes(vecs[0].count, vecs[0].w));
        wait_done();
        check_load("glitch", vecs[0].count, vecs[0].w, 1, 1'b0);

        // Asynchronous reset in the middle of word 1
        apply_reset();
        begin
            byte_q_t q;
            q = image_bytes(32'd2, vecs[2].w);
            for (int i = 0; i < 10; i++) send_byte(q[i], 0);
        end
        check("midrst.pre_write", wr_q.size(), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.we", prog_write_enable, 1'b0);
        check("midrst.cpu_reset_n", cpu_reset_n, 1'b0);
        check("midrst.addr", prog_address, 32'h0);
        check("midrst.data", prog_write_data, 32'h0);
        check("midrst.load_done", load_done, 1'b0);
        apply_reset();
        send_stream(image_bytes(32'd2, vecs[3].w));
        wait_done();
        check_load("midrst_reload", 32'd2, vecs[3].w, 2, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        apply_reset();
        foreach (spec_q[i]) send_byte(spec_q[i], 0);
        send_byte(~data_xor(spec_q), 0);
        repeat (30) @(negedge clk);
        check("csum_bad.load_error", load_error, 1'b1);
        check("csum_bad.load_done", load_done, 1'b0);
        check("csum_bad.cpu_reset_n", cpu_reset_n, 1'b0);
        check("csum_bad.writes", wr_q.size(), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
